vga_draw_engine: RTL

//  Command-driven pixel writer feeding the VGA framebuffer write port (wr_en/wr_addr/wr_data).

---
 rtl/vga_draw_engine_if.sv | 24 ++
 rtl/vga_draw_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_engine_if.sv
// Command channel between the processor (master) and the draw engine (slave).
// Valid/ready handshake; the command fields are sampled on the accepting edge.
interface vga_draw_engine_if #(
  parameter int unsigned COLOR_WIDTH = 3
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [9:0]             cmd_x0;
  logic [9:0]             cmd_y0;
  logic [9:0]             cmd_x1;
  logic [9:0]             cmd_y1;
  logic [COLOR_WIDTH-1:0] cmd_color;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/vga_draw_engine.sv
// Rasterises PLOT/RECT/CLEAR commands into row-major framebuffer writes, each held WR_HOLD cycles.
// Define VGA_DRAW_CLIP_EN to clip to the framebuffer; otherwise off-screen coordinates are rejected.
module vga_draw_engine #(
  parameter int unsigned FB_WIDTH    = 40,
  parameter int unsigned FB_HEIGHT   = 30,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned COLOR_WIDTH = 3,
  parameter int unsigned WR_HOLD     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  vga_draw_engine_if.slave       cmd,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [COLOR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpPlot  = 2'b01;
  localparam logic [1:0] OpRect  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [9:0] XLim  = 10'(FB_WIDTH);
  localparam logic [9:0] YLim  = 10'(FB_HEIGHT);
  localparam logic [9:0] XLast = 10'(FB_WIDTH - 1);
  localparam logic [9:0] YLast = 10'(FB_HEIGHT - 1);

  localparam int unsigned     HoldW    = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(WR_HOLD - 1);

  // FINISH/REJECT are folded into the return to idle so done/err coincide with cmd_ready.
  typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

  state_e state_q, state_d;

  logic [1:0]             op_q, op_d;
  logic [9:0]             x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic [9:0]             xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic [9:0]             x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [COLOR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   done_q, done_d, err_q, err_d;

  logic [9:0] s_xmin, s_xmax, s_ymin, s_ymax;
  logic       s_empty, s_reject;

  // Constant-coefficient product unrolled into shifted adds; only used once per command.
  function automatic logic [ADDR_WIDTH-1:0] row_base_of(input logic [9:0] y);
    logic [ADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (FB_WIDTH[b]) acc = acc + (ADDR_WIDTH'(y) << b);
    end
    return acc;
  endfunction

  // Bounding box of the latched command, valid while in StSetup.
  always_comb begin
    s_xmin   = '0;
    s_xmax   = '0;
    s_ymin   = '0;
    s_ymax   = '0;
    s_empty  = 1'b0;
    s_reject = 1'b0;
    case (op_q)
      OpPlot: begin
        s_xmin = x0_q;
        s_xmax = x0_q;
        s_ymin = y0_q;
        s_ymax = y0_q;
      end
      OpRect: begin
        s_xmin = (x0_q < x1_q) ? x0_q : x1_q;
        s_xmax = (x0_q < x1_q) ? x1_q : x0_q;
        s_ymin = (y0_q < y1_q) ? y0_q : y1_q;
        s_ymax = (y0_q < y1_q) ? y1_q : y0_q;
      end
      OpClear: begin
        s_xmax = XLast;
        s_ymax = YLast;
      end
      default: s_empty = 1'b1;
    endcase
`ifdef VGA_DRAW_CLIP_EN
    if (s_xmin >= XLim || s_ymin >= YLim) s_empty = 1'b1;
    if (s_xmax > XLast) s_xmax = XLast;
    if (s_ymax > YLast) s_ymax = YLast;
`else
    case (op_q)
      OpPlot:  s_reject = (x0_q >= XLim) || (y0_q >= YLim);
      OpRect:  s_reject = (x0_q >= XLim) || (x1_q >= XLim) || (y0_q >= YLim) || (y1_q >= YLim);
      default: s_reject = 1'b0;
    endcase
`endif
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymax_d     = ymax_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    hold_d     = hold_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_en_d = 1'b0;
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          x0_d    = cmd.cmd_x0;
          y0_d    = cmd.cmd_y0;
          x1_d    = cmd.cmd_x1;
          y1_d    = cmd.cmd_y1;
          color_d = cmd.cmd_color;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (s_reject) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (s_empty) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          xmin_d     = s_xmin;
          xmax_d     = s_xmax;
          ymax_d     = s_ymax;
          x_d        = s_xmin;
          y_d        = s_ymin;
          row_base_d = row_base_of(s_ymin);
          wr_addr_d  = row_base_of(s_ymin) + ADDR_WIDTH'(s_xmin);
          wr_data_d  = color_q;
          wr_en_d    = 1'b1;
          hold_d     = '0;
          state_d    = StDraw;
        end
      end
      StDraw: begin
        if (hold_q != HoldLast) begin
          hold_d = hold_q + HoldW'(1);
        end else begin
          hold_d = '0;
          // Equality tests rather than increments-then-compare so counters never pass the bound.
          if (x_q != xmax_q) begin
            x_d       = x_q + 10'd1;
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          end else if (y_q != ymax_q) begin
            x_d        = xmin_q;
            y_d        = y_q + 10'd1;
            row_base_d = row_base_q + ADDR_WIDTH'(FB_WIDTH);
            wr_addr_d  = row_base_q + ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(xmin_q);
          end else begin
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      hold_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymax_q     <= ymax_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      hold_q     <= hold_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
